// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one step per clock, WIDTH steps per op.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               is_div_q, is_div_d;
  logic               div0_q, div0_d;
  logic               neg_main_q, neg_main_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Magnitude of a possibly signed operand; MIN maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v, input logic is_signed);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    if (is_signed && v[WIDTH-1]) begin
      ext = {(WIDTH+1){1'b0}} - ext;
    end else begin
      ext = {1'b0, v};
    end
    return ext[WIDTH-1:0];
  endfunction

  logic               signed_op_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     div_shift_s;
  logic               div_ge_s;
  logic [WIDTH:0]     div_rem_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  // Datapath for one iteration step and the final sign correction.
  always_comb begin
    signed_op_s = (op == OP_MULT) || (op == OP_DIV);
    mag_a_s     = abs_w(a, signed_op_s);
    mag_b_s     = abs_w(b, signed_op_s);
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    mul_next_s  = {mul_sum_s, acc_q[WIDTH-1:1]};
    div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge_s    = div_shift_s >= {1'b0, opnd_q};
    if (div_ge_s) begin
      div_rem_s = div_shift_s - {1'b0, opnd_q};
    end else begin
      div_rem_s = div_shift_s;
    end
    div_next_s  = {div_rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge_s};
    prod_s      = neg_main_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
    quo_s       = neg_main_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_s       = neg_rem_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    a_raw_d    = a_raw_q;
    is_div_d   = is_div_q;
    div0_d     = div0_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d    = S_ITER;
              cnt_d      = {CNT_W{1'b0}};
              busy_d     = 1'b1;
              acc_d      = {{WIDTH{1'b0}}, mag_a_s};
              opnd_d     = mag_b_s;
              a_raw_d    = a;
              is_div_d   = op[1];
              div0_d     = op[1] && (b == {WIDTH{1'b0}});
              neg_main_d = signed_op_s && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_d  = signed_op_s && a[WIDTH-1];
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        if (cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = is_div_q ? div_next_s : mul_next_s;
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d = S_FIX;
          end else begin
            state_d = S_ITER;
          end
        end
      end
      S_FIX: begin
        // cancel outranks completion so a flushed op never touches HI/LO
        if (cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (!is_div_q) begin
            hi_d = prod_s[2*WIDTH-1:WIDTH];
            lo_d = prod_s[WIDTH-1:0];
          end else if (div0_q) begin
            hi_d = a_raw_q;
            lo_d = {WIDTH{1'b1}};
          end else begin
            hi_d = rem_s;
            lo_d = quo_s;
          end
          done_d  = 1'b1;
          dbz_d   = div0_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      opnd_q     <= {WIDTH{1'b0}};
      a_raw_q    <= {WIDTH{1'b0}};
      is_div_q   <= 1'b0;
      div0_q     <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      a_raw_q    <= a_raw_d;
      is_div_q   <= is_div_d;
      div0_q     <= div0_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
